// File: rtl/ysyx_24080006_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, owner tags and the latched request.
package ysyx_24080006_arb_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RSP  = 2'd2,
    ARB_RET  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0]   addr;
    logic                    we;
    logic [ARB_DATA_W-1:0]   wdata;
    logic [ARB_DATA_W/8-1:0] wstrb;
  } mem_req_t;

endpackage

// File: rtl/ysyx_24080006_arb_timer.sv
// Watchdog for one outstanding downstream transaction; expired marks the last
// allowed cycle so the arbiter lands in RET TIMEOUT_CYC cycles after entering REQ.
module ysyx_24080006_arb_timer #(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CW'(1);
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/ysyx_24080006_mem_arb.sv
// Two-master (IFU, LSU) to one-slave memory arbiter, one transaction in flight, LSU wins ties.
// Optional watchdog: define YSYX_24080006_ARB_TIMEOUT_EN.
module ysyx_24080006_mem_arb
  import ysyx_24080006_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = ARB_ADDR_W,
  parameter int unsigned DATA_W      = ARB_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  input  logic                ifu_rsp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_we,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_rsp_valid,
  input  logic                lsu_rsp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rsp_err
);

  arb_state_e        state;
  arb_owner_e        owner;
  mem_req_t          req_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              tmo;
  logic              idle, ret;

  assign idle = (state == ARB_IDLE);
  assign ret  = (state == ARB_RET);

`ifdef YSYX_24080006_ARB_TIMEOUT_EN
  ysyx_24080006_arb_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (idle),
    .en      ((state == ARB_REQ) || (state == ARB_RSP)),
    .expired (tmo)
  );
`else
  localparam bit TMO_EN = 1'b0;
  assign tmo = TMO_EN && (TIMEOUT_CYC != 0);
`endif

  assign lsu_req_ready = idle && lsu_req_valid;
  assign ifu_req_ready = idle && ifu_req_valid && !lsu_req_valid;

  // Handshakes are withheld on the expiry cycle so nothing is accepted that is then abandoned.
  assign mem_req_valid = (state == ARB_REQ) && !tmo;
  assign mem_rsp_ready = (state == ARB_RSP) && !tmo;
  assign mem_addr      = req_q.addr;
  assign mem_we        = req_q.we;
  assign mem_wdata     = req_q.wdata;
  assign mem_wstrb     = req_q.wstrb;

  assign ifu_rsp_valid = ret && (owner == OWN_IFU);
  assign lsu_rsp_valid = ret && (owner == OWN_LSU);
  assign ifu_rdata     = ifu_rsp_valid ? rdata_q : '0;
  assign ifu_rsp_err   = ifu_rsp_valid && err_q;
  assign lsu_rdata     = lsu_rsp_valid ? rdata_q : '0;
  assign lsu_rsp_err   = lsu_rsp_valid && err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ARB_IDLE;
      owner   <= OWN_IFU;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (lsu_req_valid) begin
            owner <= OWN_LSU;
            req_q <= '{addr: lsu_addr, we: lsu_we, wdata: lsu_wdata, wstrb: lsu_wstrb};
            state <= ARB_REQ;
          end else if (ifu_req_valid) begin
            owner <= OWN_IFU;
            req_q <= '{addr: ifu_addr, we: 1'b0, wdata: '0, wstrb: '0};
            state <= ARB_REQ;
          end
        end
        ARB_REQ, ARB_RSP: begin
          if (tmo) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= ARB_RET;
          end else if (state == ARB_REQ) begin
            if (mem_req_ready) state <= ARB_RSP;
          end else if (mem_rsp_valid) begin
            // Stores still answer, but never with read data.
            rdata_q <= req_q.we ? '0 : mem_rdata;
            err_q   <= mem_rsp_err;
            state   <= ARB_RET;
          end
        end
        ARB_RET: begin
          if ((owner == OWN_IFU) ? ifu_rsp_ready : lsu_rsp_ready) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_mem_arb.sv
// Directed, table-driven bench for the IFU/LSU memory arbiter.
module tb_ysyx_24080006_mem_arb;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ifu_req_valid = 1'b0, ifu_req_ready;
  logic [31:0] ifu_addr = '0;
  logic        ifu_rsp_valid, ifu_rsp_ready = 1'b0;
  logic [31:0] ifu_rdata;
  logic        ifu_rsp_err;
  logic        lsu_req_valid = 1'b0, lsu_req_ready;
  logic [31:0] lsu_addr = '0;
  logic        lsu_we = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wstrb = '0;
  logic        lsu_rsp_valid, lsu_rsp_ready = 1'b0;
  logic [31:0] lsu_rdata;
  logic        lsu_rsp_err;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid = 1'b0, mem_rsp_ready;
  logic [31:0] mem_rdata = '0;
  logic        mem_rsp_err = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ysyx_24080006_mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
    .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_we(lsu_we), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
    .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata),
    .mem_rsp_err(mem_rsp_err)
  );

  typedef struct {
    bit          lsu;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] srd;
    bit          serr;
    logic [31:0] exp_rd;
    bit          exp_err;
    logic        exp_we;
    logic [31:0] exp_wd;
    logic [3:0]  exp_ws;
  } vec_t;

  vec_t tbl[6];

  function automatic vec_t mk(bit lsu, bit we, logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] wstrb, logic [31:0] srd, bit serr,
                              logic [31:0] exp_rd, bit exp_err, logic exp_we,
                              logic [31:0] exp_wd, logic [3:0] exp_ws);
    vec_t v;
    v.lsu = lsu; v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
    v.srd = srd; v.serr = serr; v.exp_rd = exp_rd; v.exp_err = exp_err;
    v.exp_we = exp_we; v.exp_wd = exp_wd; v.exp_ws = exp_ws;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Starts in IDLE at a negedge; returns in IDLE at a negedge.
  task automatic run_txn(input string tag, input vec_t v, input int req_wait,
                         input int rsp_wait, input int ret_hold, input bit pend);
    if (v.lsu) begin
      lsu_req_valid = 1'b1; lsu_addr = v.addr; lsu_we = v.we;
      lsu_wdata = v.wdata; lsu_wstrb = v.wstrb;
    end else begin
      ifu_req_valid = 1'b1; ifu_addr = v.addr;
    end
    #1;
    chk({tag, ".grant"}, v.lsu ? lsu_req_ready : ifu_req_ready, 1);
    if (pend) chk({tag, ".tie_ifu_rdy"}, ifu_req_ready, 0);
    @(negedge clock);
    // upstream fields change after the handshake and must not matter
    if (v.lsu) begin
      lsu_req_valid = 1'b0; lsu_addr = ~v.addr; lsu_we = ~v.we;
      lsu_wdata = ~v.wdata; lsu_wstrb = ~v.wstrb;
    end else begin
      ifu_req_valid = 1'b0; ifu_addr = ~v.addr;
    end
    for (int i = 0; i <= req_wait; i++) begin
      mem_req_ready = (i == req_wait);
      mem_rsp_valid = (i != req_wait);
      mem_rdata = 32'h5A5A_5A5A; mem_rsp_err = 1'b1;
      #1;
      chk({tag, ".req_valid"}, mem_req_valid, 1);
      chk({tag, ".mem_addr"}, mem_addr, v.addr);
      chk({tag, ".mem_we"}, mem_we, v.exp_we);
      chk({tag, ".mem_wdata"}, mem_wdata, v.exp_wd);
      chk({tag, ".mem_wstrb"}, mem_wstrb, v.exp_ws);
      chk({tag, ".req_rdys"}, {ifu_req_ready, lsu_req_ready, mem_rsp_ready}, 0);
      chk({tag, ".req_rspv"}, {ifu_rsp_valid, lsu_rsp_valid}, 0);
      @(negedge clock);
    end
    mem_req_ready = 1'b0;
    for (int i = 0; i <= rsp_wait; i++) begin
      mem_rsp_valid = (i == rsp_wait);
      mem_rdata = (i == rsp_wait) ? v.srd : 32'h0;
      mem_rsp_err = (i == rsp_wait) ? v.serr : 1'b0;
      #1;
      chk({tag, ".rsp_ready"}, mem_rsp_ready, 1);
      chk({tag, ".rsp_reqv"}, mem_req_valid, 0);
      chk({tag, ".rsp_rspv"}, {ifu_rsp_valid, lsu_rsp_valid, ifu_req_ready, lsu_req_ready}, 0);
      @(negedge clock);
    end
    mem_rsp_valid = 1'b0; mem_rdata = 32'h0; mem_rsp_err = 1'b0;
    for (int i = 0; i <= ret_hold; i++) begin
      if (v.lsu) lsu_rsp_ready = (i == ret_hold); else ifu_rsp_ready = (i == ret_hold);
      #1;
      chk({tag, ".ret_valid"}, v.lsu ? lsu_rsp_valid : ifu_rsp_valid, 1);
      chk({tag, ".ret_rdata"}, v.lsu ? lsu_rdata : ifu_rdata, v.exp_rd);
      chk({tag, ".ret_err"}, v.lsu ? lsu_rsp_err : ifu_rsp_err, v.exp_err);
      chk({tag, ".ret_other"}, v.lsu ? ifu_rsp_valid : lsu_rsp_valid, 0);
      chk({tag, ".ret_quiet"}, {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready}, 0);
      @(negedge clock);
    end
    ifu_rsp_ready = 1'b0; lsu_rsp_ready = 1'b0;
  endtask

  initial begin
    tbl[0] = mk(0, 0, 32'h8000_0000, 32'h0, 4'h0, 32'h0000_0413, 0, 32'h0000_0413, 0, 0, 32'h0, 4'h0);
    tbl[1] = mk(1, 0, 32'h8000_0004, 32'h1111_2222, 4'h0, 32'h1234_5678, 0, 32'h1234_5678, 0, 0, 32'h1111_2222, 4'h0);
    tbl[2] = mk(1, 1, 32'h8000_0008, 32'hCAFE_F00D, 4'hF, 32'hFFFF_FFFF, 0, 32'h0, 0, 1, 32'hCAFE_F00D, 4'hF);
    tbl[3] = mk(1, 0, 32'h0000_0000, 32'h0, 4'h0, 32'hBAD0_BAD0, 1, 32'hBAD0_BAD0, 1, 0, 32'h0, 4'h0);
    tbl[4] = mk(0, 0, 32'h8000_0010, 32'h0, 4'h0, 32'h0010_0073, 0, 32'h0010_0073, 0, 0, 32'h0, 4'h0);
    tbl[5] = mk(1, 1, 32'h8000_0020, 32'h0000_00AB, 4'h1, 32'h7777_7777, 1, 32'h0, 1, 1, 32'h0000_00AB, 4'h1);

    @(negedge clock);
    @(negedge clock);
    chk("rst.valids", {mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}, 0);
    chk("rst.readies", {ifu_req_ready, lsu_req_ready}, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.we_wstrb", {mem_we, mem_wstrb}, 0);
    chk("rst.rsp_data", {ifu_rdata ^ lsu_rdata}, 0);
    chk("rst.rsp_err", {ifu_rsp_err, lsu_rsp_err}, 0);
    reset = 1'b0;
    @(negedge clock);

    foreach (tbl[i]) run_txn($sformatf("v%0d", i), tbl[i], 0, 0, 0, 0);

    // Simultaneous requests: LSU store wins, IFU stays pending then wins next IDLE.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
    run_txn("tie_lsu", mk(1, 1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011, 32'h0, 0, 32'h0, 0, 1,
                          32'hDEAD_BEEF, 4'b0011), 0, 0, 0, 1);
    run_txn("tie_ifu", mk(0, 0, 32'h8000_0040, 32'h0, 4'h0, 32'h0000_0013, 0, 32'h0000_0013, 0, 0,
                          32'h0, 4'h0), 0, 0, 0, 0);

    // Slave stalls request 5 cycles (with a stray rsp_valid) and response 2 cycles.
    run_txn("stall", mk(1, 1, 32'h8000_2000, 32'h0BAD_F00D, 4'hC, 32'h0, 0, 32'h0, 0, 1,
                        32'h0BAD_F00D, 4'hC), 5, 2, 0, 0);

    // Owner withholds rsp_ready for 3 cycles.
    run_txn("hold", mk(0, 0, 32'h8000_3000, 32'h0, 4'h0, 32'hA5A5_0001, 0, 32'hA5A5_0001, 0, 0,
                       32'h0, 4'h0), 0, 0, 3, 0);

    // Reset while in RSP abandons the transaction.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_4000;
    @(negedge clock);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    #1;
    chk("rstrsp.in_rsp", mem_rsp_ready, 1);
    reset = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h1357_9BDF;
    @(negedge clock);
    reset = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
    #1;
    chk("rstrsp.valids", {mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}, 0);
    chk("rstrsp.addr", mem_addr, 0);
    lsu_req_valid = 1'b1;
    #1;
    chk("rstrsp.idle", lsu_req_ready, 1);
    lsu_req_valid = 1'b0;
    @(negedge clock);

`ifdef YSYX_24080006_ARB_TIMEOUT_EN
    begin
      int found;
      found = -1;
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_5000;
      @(negedge clock);
      ifu_req_valid = 1'b0;
      for (int c = 0; c < 20 && found < 0; c++) begin
        #1;
        if (c == 0) chk("tmo.req_v0", mem_req_valid, 1);
        if (c == 7) chk("tmo.req_drop", mem_req_valid, 0);
        if (ifu_rsp_valid) found = c;
        else @(negedge clock);
      end
      chk("tmo.cycle", found, 8);
      chk("tmo.err", ifu_rsp_err, 1);
      chk("tmo.rdata", ifu_rdata, 0);
      mem_rsp_valid = 1'b1; mem_rdata = 32'h2468_ACE0;
      @(negedge clock);
      mem_rsp_valid = 1'b0;
      #1;
      chk("tmo.late_rdata", ifu_rdata, 0);
      chk("tmo.late_err", ifu_rsp_err, 1);
      ifu_rsp_ready = 1'b1;
      @(negedge clock);
      ifu_rsp_ready = 1'b0;
      #1;
      chk("tmo.idle", {ifu_rsp_valid, mem_req_valid}, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_24080006_mem_arb.md
Name: ysyx_24080006_mem_arb

Overview:
- Two-master, one-slave memory arbiter for the multicycle RV32E core.
- Shares the single memory/bus port between the instruction-fetch requester (IFU, read-only) and the load/store requester (LSU, read/write).
- Sits between IFU/LSU and the SRAM/bus bridge.
- Upstream and downstream channels all use valid/ready; one transaction is outstanding at a time.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- TIMEOUT_CYC, 1023, watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted
- ifu_addr  in  ADDR_W  fetch address
- ifu_rsp_valid  out  1  IFU response valid
- ifu_rsp_ready  in  1  IFU takes response
- ifu_rdata  out  DATA_W  fetched word
- ifu_rsp_err  out  1  bus/timeout error
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted
- lsu_addr  in  ADDR_W  load/store address
- lsu_we  in  1  1=store
- lsu_wdata  in  DATA_W  store data
- lsu_wstrb  in  DATA_W/8  byte strobes
- lsu_rsp_valid  out  1  LSU response valid
- lsu_rsp_ready  in  1  LSU takes response
- lsu_rdata  out  DATA_W  load data
- lsu_rsp_err  out  1  error
- mem_req_valid  out  1  downstream request
- mem_req_ready  in  1  downstream accepts
- mem_addr / mem_we / mem_wdata / mem_wstrb  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields
- mem_rsp_valid  in  1  downstream response
- mem_rsp_ready  out  1  arbiter takes response
- mem_rdata  in  DATA_W  read data
- mem_rsp_err  in  1  downstream error

Behaviour:
- Reset:
  - All valid/ready outputs 0, owner=IFU, state IDLE.
  - Latched addr/wdata/wstrb/we/rdata/err all 0.
  - Reset mid-transaction abandons the transaction; the downstream is reset together with the arbiter.
- FSM states: IDLE, REQ, RSP, RET.
- IDLE:
  - lsu_req_ready = lsu_req_valid (combinational).
  - ifu_req_ready = ifu_req_valid & ~lsu_req_valid.
  - LSU has fixed priority on a tie.
  - On a handshake: latch requester fields (IFU forces we=0, wstrb=0, wdata=0) and owner, then go to REQ.
- REQ:
  - mem_req_valid=1 with latched fields held stable.
  - On mem_req_ready go to RSP.
- RSP:
  - mem_rsp_ready=1.
  - On mem_rsp_valid latch rdata/err and go to RET.
  - A mem_rsp_valid seen in REQ is ignored.
- RET:
  - Owner's rsp_valid=1 with latched rdata/err; the other requester's rsp_valid=0.
  - On owner rsp_ready go to IDLE.
  - Stores also return a response: rdata=0, err as latched.
- Latency: request accepted at cycle N → mem_req_valid at N+1; zero-wait slave → owner rsp_valid at N+3. Minimum 4 cycles per transaction, because IDLE is re-entered before the next grant.
- Requests from the losing requester stay pending; its ready stays 0 until IDLE with no LSU request present.
- Non-owner ready/response outputs stay 0 during REQ/RSP/RET.
- Upstream fields may change after the handshake without effect.

Optional Feature:
- Macro: YSYX_24080006_ARB_TIMEOUT_EN.
- Enabled:
  - A cycle counter clears on entry to REQ and increments each cycle in REQ/RSP.
  - When it reaches TIMEOUT_CYC, go to RET with err=1 and rdata=0.
  - mem_req_valid/mem_rsp_ready drop that cycle.
  - A late mem_rsp_valid after the timeout is ignored.
- Disabled: no counter; the arbiter waits indefinitely.

Decomposition:
- Package ysyx_24080006_arb_pkg:
  - state enum (IDLE/REQ/RSP/RET)
  - owner enum (OWN_IFU/OWN_LSU)
  - packed mem_req_t struct (addr, we, wdata, wstrb)
- Sub-module ysyx_24080006_arb_timer (the watchdog counter), instantiated only under the macro.

Test Plan:
- IFU read 0x8000_0000, slave zero-wait returns 0x0000_0413 → ifu_rsp_valid 3 cycles after the handshake with rdata 0x0000_0413, err=0; lsu_rsp_valid stays 0.
- IFU and LSU request in the same cycle (LSU store 0x8000_1000, wdata 0xDEADBEEF, wstrb 4'b0011) → LSU granted first and mem_wstrb=0011; IFU granted in the IDLE after LSU RET completes.
- mem_req_ready held low for 5 cycles → mem_addr/mem_wdata stable throughout; no upstream ready pulses.
- Owner holds rsp_ready=0 for 3 cycles in RET → rsp_valid and rdata held; no new grant until release.
- Slave returns mem_rsp_err=1 on LSU load 0x0000_0000 → lsu_rsp_err=1; IFU's next fetch unaffected (err=0).
- With the macro and TIMEOUT_CYC=8, slave never responds → owner rsp_valid with err=1, rdata=0 on cycle 8 after entering REQ. Separately: reset asserted in RSP → next cycle all valids 0, state IDLE.
